// File: rtl/lvds_link_trainer.sv
// Word-alignment / link-training controller for the 11-lane DDR LVDS camera receiver.
// Slips the deserializer word boundary until the far-end training word is stable, then holds lock.

module lvds_lane_cmp #(
  parameter int VEC_W = 8
) (
  input  logic [VEC_W-1:0] data_i,
  input  logic [VEC_W-1:0] pat_i,
  output logic             match_o,
  output logic             nz_o
);
  assign match_o = (data_i == pat_i);
  assign nz_o    = |data_i;
endmodule

module lvds_link_trainer #(
  parameter int                DWIDTH        = 88,
  parameter logic [DWIDTH-1:0] CAL_PATTERN   = 88'h005A55FEDCBA9876543210,
  parameter int                SETTLE_CYCLES = 16,
  parameter int                LOCK_COUNT    = 8,
  parameter int                MAX_SLIPS     = 32,
  parameter int                RST_CYCLES    = 8
) (
  input  logic              i_rx_sclk,
  input  logic              rx_drst,
  input  logic              i_enable,
  input  logic              i_retrain,
  input  logic              i_rx_ready,
  input  logic [DWIDTH-1:0] i_rx_data,
  output logic              o_align,
  output logic              o_retrain_rst,
  output logic              o_lock,
  output logic [2:0]        o_state,
  output logic [5:0]        o_slip_cnt,
  output logic [7:0]        o_fail_cnt,
  output logic [7:0]        o_loss_cnt
);
  localparam int VEC_W     = 8;
  localparam int NUM_LANES = DWIDTH / VEC_W;

  localparam logic [7:0] SET_M1  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOCK_M1 = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] RST_M1  = 8'(RST_CYCLES - 1);
  localparam logic [5:0] SLIP_MX = 6'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  // Per-lane byte compare; a full-word match needs every lane, "far end idle" needs none.
  logic [NUM_LANES-1:0][VEC_W-1:0] data_lanes, pat_lanes;
  logic [NUM_LANES-1:0]            lane_match, lane_nz;
  logic                            pat_match, data_nz;

  assign data_lanes = i_rx_data;
  assign pat_lanes  = CAL_PATTERN;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lvds_lane_cmp #(.VEC_W(VEC_W)) u_cmp (
      .data_i  (data_lanes[l]),
      .pat_i   (pat_lanes[l]),
      .match_o (lane_match[l]),
      .nz_o    (lane_nz[l])
    );
  end

  assign pat_match = &lane_match;
  assign data_nz   = |lane_nz;

  state_e     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [7:0] match_q, match_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic [5:0] slip_q, slip_d;
  logic [7:0] fail_q, fail_d;
  logic [7:0] loss_q, loss_d;
  logic       align_q, align_d;
  logic       lock_q, rrst_q;

  always_comb begin
    state_d   = state_q;
    settle_d  = '0;
    match_d   = '0;
    rst_cnt_d = '0;
    slip_d    = slip_q;
    fail_d    = fail_q;
    loss_d    = loss_q;
    align_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_enable && i_rx_ready) begin
          state_d = S_SETTLE;
          slip_d  = '0;
        end
      end
      S_SETTLE: begin
        if (!i_enable || !i_rx_ready || i_retrain) state_d = S_IDLE;
        else if (settle_q == SET_M1)               state_d = S_CHECK;
        else                                       settle_d = settle_q + 8'd1;
      end
      S_CHECK: begin
        if (!i_enable || !i_rx_ready || i_retrain) begin
          state_d = S_IDLE;
        end else if (pat_match) begin
          if (match_q == LOCK_M1) state_d = S_LOCKED;
          else                    match_d = match_q + 8'd1;
        end else if (data_nz) begin
          // Zero words mean the far end is idle: wait rather than slip.
          align_d = 1'b1;
          slip_d  = slip_q + 6'd1;
          if (slip_q + 6'd1 == SLIP_MX) begin
            state_d = S_FAIL;
            fail_d  = (fail_q != 8'hFF) ? fail_q + 8'd1 : fail_q;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_LOCKED: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (!i_rx_ready) begin
          state_d = S_IDLE;
          loss_d  = (loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
        end else if (i_retrain) begin
          state_d = S_IDLE;
        end
      end
      S_FAIL: begin
        if (rst_cnt_q == RST_M1) state_d = S_IDLE;
        else                     rst_cnt_d = rst_cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_rx_sclk or posedge rx_drst) begin
    if (rx_drst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      match_q   <= '0;
      rst_cnt_q <= '0;
      slip_q    <= '0;
      fail_q    <= '0;
      loss_q    <= '0;
      align_q   <= 1'b0;
      lock_q    <= 1'b0;
      rrst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      rst_cnt_q <= rst_cnt_d;
      slip_q    <= slip_d;
      fail_q    <= fail_d;
      loss_q    <= loss_d;
      align_q   <= align_d;
      lock_q    <= (state_d == S_LOCKED);
      rrst_q    <= (state_d == S_FAIL);
    end
  end

  assign o_align       = align_q;
  assign o_retrain_rst = rrst_q;
  assign o_lock        = lock_q;
  assign o_state       = state_q;
  assign o_slip_cnt    = slip_q;
  assign o_fail_cnt    = fail_q;
  assign o_loss_cnt    = loss_q;
endmodule
